// File: rtl/vgachargen_apb_if_if.sv
// APB3 slave bus bundle for the VGA character-generator register port.
// Signal names keep the slave-side _i/_o suffixes so the bus reads the same
// at both ends; the modports give each side its direction.
interface vgachargen_apb_if_if;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [15:0] paddr_i;
  logic [31:0] pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;

  modport slave (
    input  psel_i,
    input  penable_i,
    input  pwrite_i,
    input  paddr_i,
    input  pwdata_i,
    output prdata_o,
    output pready_o,
    output pslverr_o
  );

  modport master (
    output psel_i,
    output penable_i,
    output pwrite_i,
    output paddr_i,
    output pwdata_i,
    input  prdata_o,
    input  pready_o,
    input  pslverr_o
  );
endinterface

// File: rtl/vgachargen_apb_if.sv
// APB3 slave giving the CPU access to the VGA text-mode memories: the
// character map, the colour map and the 128-bit-wide glyph table.
// Memory A-ports have one cycle of read latency. Glyph rows are wider than
// the bus, so a glyph write is a read-modify-write of one 32-bit word.
module vgachargen_apb_if #(
  parameter  int COLS      = 80,
  parameter  int ROWS      = 30,
  parameter  int GLYPHS    = 128,
  localparam int MAP_DEPTH = COLS * ROWS,
  localparam int MAP_AW    = $clog2(MAP_DEPTH),
  localparam int GLYPH_AW  = $clog2(GLYPHS)
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  vgachargen_apb_if_if.slave     apb,
  output logic [MAP_AW-1:0]      ch_map_addr_o,
  output logic [7:0]             ch_map_data_o,
  output logic                   ch_map_wen_o,
  input  logic [7:0]             ch_map_data_i,
  output logic [MAP_AW-1:0]      col_map_addr_o,
  output logic [7:0]             col_map_data_o,
  output logic                   col_map_wen_o,
  input  logic [7:0]             col_map_data_i,
  output logic [GLYPH_AW-1:0]    ch_t_addr_o,
  output logic [127:0]           ch_t_data_o,
  output logic                   ch_t_wen_o,
  input  logic [127:0]           ch_t_data_i
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    RD_WAIT   = 3'd2,
    RMW_MERGE = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam logic [1:0] RG_CH  = 2'd0;
  localparam logic [1:0] RG_COL = 2'd1;
  localparam logic [1:0] RG_GLY = 2'd2;
  localparam logic [1:0] RG_BAD = 2'd3;

  localparam logic [31:0] MAP_LIM   = 32'(MAP_DEPTH);
  localparam logic [31:0] GLYPH_LIM = 32'(4 * GLYPHS);

  // Pick one 32-bit word out of a glyph row.
  function automatic logic [31:0] glyph_word(input logic [127:0] row,
                                             input logic [1:0]   w);
    return row[32*w +: 32];
  endfunction

  // Replace one 32-bit word of a glyph row, leaving the other 96 bits intact.
  function automatic logic [127:0] glyph_merge(input logic [127:0] row,
                                               input logic [1:0]   w,
                                               input logic [31:0]  word);
    logic [127:0] res;
    res = row;
    res[32*w +: 32] = word;
    return res;
  endfunction

  // Address decode of the bus as presented in the SETUP phase.
  logic [1:0]  region_in;
  logic [11:0] idx_in;
  logic        invalid_in;

  assign region_in = apb.paddr_i[15:14];
  assign idx_in    = apb.paddr_i[13:2];

  // Byte lane bits and PENABLE carry no information for this slave.
  logic unused_bits;
  assign unused_bits = ^{apb.penable_i, apb.paddr_i[1:0]};

  // Flag out-of-range or reserved-region accesses.
  always_comb begin
    invalid_in = 1'b0;
    case (region_in)
      RG_CH, RG_COL: invalid_in = ({20'd0, idx_in} >= MAP_LIM);
      RG_GLY:        invalid_in = ({20'd0, idx_in} >= GLYPH_LIM);
      default:       invalid_in = 1'b1;
    endcase
  end

  state_t                state_q, state_d;
  logic [1:0]            region_q, region_d;
  logic [1:0]            word_q, word_d;
  logic                  write_q, write_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  invalid_q, invalid_d;
  logic [31:0]           prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [MAP_AW-1:0]     ch_map_addr_q, ch_map_addr_d;
  logic [7:0]            ch_map_data_q, ch_map_data_d;
  logic                  ch_map_wen_q, ch_map_wen_d;
  logic [MAP_AW-1:0]     col_map_addr_q, col_map_addr_d;
  logic [7:0]            col_map_data_q, col_map_data_d;
  logic                  col_map_wen_q, col_map_wen_d;
  logic [GLYPH_AW-1:0]   ch_t_addr_q, ch_t_addr_d;
  logic [127:0]          ch_t_data_q, ch_t_data_d;
  logic                  ch_t_wen_q, ch_t_wen_d;

  // Next-state and registered-output logic for the transfer sequencer.
  // Write enables and PREADY default low, so each is a one-cycle pulse.
  always_comb begin
    state_d        = state_q;
    region_d       = region_q;
    word_d         = word_q;
    write_d        = write_q;
    wdata_d        = wdata_q;
    invalid_d      = invalid_q;
    prdata_d       = 32'd0;
    pready_d       = 1'b0;
    pslverr_d      = 1'b0;
    ch_map_addr_d  = ch_map_addr_q;
    ch_map_data_d  = ch_map_data_q;
    ch_map_wen_d   = 1'b0;
    col_map_addr_d = col_map_addr_q;
    col_map_data_d = col_map_data_q;
    col_map_wen_d  = 1'b0;
    ch_t_addr_d    = ch_t_addr_q;
    ch_t_data_d    = ch_t_data_q;
    ch_t_wen_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (apb.psel_i) begin
          // Capture the whole request now so the memory address (and a map
          // write pulse) is already on the A-port during DECODE.
          state_d   = DECODE;
          region_d  = region_in;
          word_d    = apb.paddr_i[3:2];
          write_d   = apb.pwrite_i;
          wdata_d   = apb.pwdata_i;
          invalid_d = invalid_in;
          if (!invalid_in) begin
            case (region_in)
              RG_CH: begin
                ch_map_addr_d = idx_in[MAP_AW-1:0];
                if (apb.pwrite_i) begin
                  ch_map_data_d = apb.pwdata_i[7:0];
                  ch_map_wen_d  = 1'b1;
                end
              end
              RG_COL: begin
                col_map_addr_d = idx_in[MAP_AW-1:0];
                if (apb.pwrite_i) begin
                  col_map_data_d = apb.pwdata_i[7:0];
                  col_map_wen_d  = 1'b1;
                end
              end
              RG_GLY: begin
                ch_t_addr_d = idx_in[GLYPH_AW+1:2];
              end
              default: begin
              end
            endcase
          end
        end
      end

      DECODE: begin
        if (!apb.psel_i) begin
          state_d = IDLE;
        end else if (invalid_q) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else if (write_q && (region_q != RG_GLY)) begin
          state_d  = RESP;
          pready_d = 1'b1;
        end else begin
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        // Read data for the address driven in DECODE is valid here.
        if (!apb.psel_i) begin
          state_d = IDLE;
        end else if (write_q) begin
          state_d     = RMW_MERGE;
          ch_t_data_d = glyph_merge(ch_t_data_i, word_q, wdata_q);
          ch_t_wen_d  = 1'b1;
        end else begin
          state_d  = RESP;
          pready_d = 1'b1;
          case (region_q)
            RG_CH:   prdata_d = {24'd0, ch_map_data_i};
            RG_COL:  prdata_d = {24'd0, col_map_data_i};
            RG_GLY:  prdata_d = glyph_word(ch_t_data_i, word_q);
            default: prdata_d = 32'd0;
          endcase
        end
      end

      RMW_MERGE: begin
        if (!apb.psel_i) begin
          state_d = IDLE;
        end else begin
          state_d  = RESP;
          pready_d = 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears every output immediately.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q        <= IDLE;
      region_q       <= RG_CH;
      word_q         <= 2'd0;
      write_q        <= 1'b0;
      wdata_q        <= 32'd0;
      invalid_q      <= 1'b0;
      prdata_q       <= 32'd0;
      pready_q       <= 1'b0;
      pslverr_q      <= 1'b0;
      ch_map_addr_q  <= '0;
      ch_map_data_q  <= 8'd0;
      ch_map_wen_q   <= 1'b0;
      col_map_addr_q <= '0;
      col_map_data_q <= 8'd0;
      col_map_wen_q  <= 1'b0;
      ch_t_addr_q    <= '0;
      ch_t_data_q    <= 128'd0;
      ch_t_wen_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      region_q       <= region_d;
      word_q         <= word_d;
      write_q        <= write_d;
      wdata_q        <= wdata_d;
      invalid_q      <= invalid_d;
      prdata_q       <= prdata_d;
      pready_q       <= pready_d;
      pslverr_q      <= pslverr_d;
      ch_map_addr_q  <= ch_map_addr_d;
      ch_map_data_q  <= ch_map_data_d;
      ch_map_wen_q   <= ch_map_wen_d;
      col_map_addr_q <= col_map_addr_d;
      col_map_data_q <= col_map_data_d;
      col_map_wen_q  <= col_map_wen_d;
      ch_t_addr_q    <= ch_t_addr_d;
      ch_t_data_q    <= ch_t_data_d;
      ch_t_wen_q     <= ch_t_wen_d;
    end
  end

  assign apb.prdata_o   = prdata_q;
  assign apb.pready_o   = pready_q;
  assign apb.pslverr_o  = pslverr_q;
  assign ch_map_addr_o  = ch_map_addr_q;
  assign ch_map_data_o  = ch_map_data_q;
  assign ch_map_wen_o   = ch_map_wen_q;
  assign col_map_addr_o = col_map_addr_q;
  assign col_map_data_o = col_map_data_q;
  assign col_map_wen_o  = col_map_wen_q;
  assign ch_t_addr_o    = ch_t_addr_q;
  assign ch_t_data_o    = ch_t_data_q;
  assign ch_t_wen_o     = ch_t_wen_q;

endmodule

// File: tb/tb_vgachargen_apb_if.sv
// Directed bench for vgachargen_apb_if: APB master tasks, behavioural
// one-cycle-latency memories, and hand-computed expected values.
module tb_vgachargen_apb_if;
  localparam int MAP_AW   = 12;
  localparam int GLYPH_AW = 7;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  vgachargen_apb_if_if apb();

  logic [MAP_AW-1:0]   ch_map_addr, col_map_addr;
  logic [7:0]          ch_map_wdata, col_map_wdata;
  logic [7:0]          ch_map_rdata, col_map_rdata;
  logic                ch_map_wen, col_map_wen, ch_t_wen;
  logic [GLYPH_AW-1:0] ch_t_addr;
  logic [127:0]        ch_t_wdata, ch_t_rdata;

  vgachargen_apb_if dut (
    .clk_i          (clk),
    .arstn_i        (arstn),
    .apb            (apb),
    .ch_map_addr_o  (ch_map_addr),
    .ch_map_data_o  (ch_map_wdata),
    .ch_map_wen_o   (ch_map_wen),
    .ch_map_data_i  (ch_map_rdata),
    .col_map_addr_o (col_map_addr),
    .col_map_data_o (col_map_wdata),
    .col_map_wen_o  (col_map_wen),
    .col_map_data_i (col_map_rdata),
    .ch_t_addr_o    (ch_t_addr),
    .ch_t_data_o    (ch_t_wdata),
    .ch_t_wen_o     (ch_t_wen),
    .ch_t_data_i    (ch_t_rdata)
  );

  // Behavioural memories with one cycle of read latency, plus pulse counters.
  logic [7:0]   ch_mem  [0:4095];
  logic [7:0]   col_mem [0:4095];
  logic [127:0] gl_mem  [0:127];
  int ch_cnt = 0, col_cnt = 0, gl_cnt = 0, multi_wen = 0;
  logic [MAP_AW-1:0]   ch_last_addr, col_last_addr;
  logic [7:0]          ch_last_data, col_last_data;
  logic [GLYPH_AW-1:0] gl_last_addr;
  logic [127:0]        gl_last_data;

  always @(posedge clk) begin
    if (ch_map_wen) begin
      ch_mem[ch_map_addr] <= ch_map_wdata;
      ch_cnt <= ch_cnt + 1;
      ch_last_addr <= ch_map_addr;
      ch_last_data <= ch_map_wdata;
    end
    if (col_map_wen) begin
      col_mem[col_map_addr] <= col_map_wdata;
      col_cnt <= col_cnt + 1;
      col_last_addr <= col_map_addr;
      col_last_data <= col_map_wdata;
    end
    if (ch_t_wen) begin
      gl_mem[ch_t_addr] <= ch_t_wdata;
      gl_cnt <= gl_cnt + 1;
      gl_last_addr <= ch_t_addr;
      gl_last_data <= ch_t_wdata;
    end
    if ((int'(ch_map_wen) + int'(col_map_wen) + int'(ch_t_wen)) > 1)
      multi_wen <= multi_wen + 1;
    ch_map_rdata  <= ch_mem[ch_map_addr];
    col_map_rdata <= col_mem[col_map_addr];
    ch_t_rdata    <= gl_mem[ch_t_addr];
  end

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One APB transfer starting at the next rising edge. With corrupt set the
  // master changes address, data and direction in the ACCESS phase.
  task automatic apb_xfer(input string tag, input logic wr, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic corrupt,
                          output logic [31:0] rdata, output logic err, output int lat);
    logic seen;
    seen = 1'b0; lat = 0; rdata = 32'd0; err = 1'b0;
    @(posedge clk); #1;
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = wr;
    apb.paddr_i = addr; apb.pwdata_i = wdata;
    @(posedge clk); #1;
    apb.penable_i = 1'b1; lat = 1;
    if (corrupt) begin
      apb.paddr_i = addr ^ 16'h0ff0; apb.pwdata_i = ~wdata; apb.pwrite_i = ~wr;
    end
    while (!seen && lat < 20) begin
      @(negedge clk);
      if (apb.pready_o) begin
        seen = 1'b1; rdata = apb.prdata_o; err = apb.pslverr_o;
      end else begin
        @(posedge clk); #1; lat++;
      end
    end
    check({tag, "_ready"}, 128'(seen), 128'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      apb.psel_i = 1'b0; apb.penable_i = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_prdata"}, 128'(apb.prdata_o), 128'd0);
    check({tag, "_pready"}, 128'(apb.pready_o), 128'd0);
    check({tag, "_pslverr"}, 128'(apb.pslverr_o), 128'd0);
    check({tag, "_wens"}, 128'({ch_map_wen, col_map_wen, ch_t_wen}), 128'd0);
    check({tag, "_addrs"}, 128'({ch_map_addr, col_map_addr, ch_t_addr}), 128'd0);
    check({tag, "_mapdata"}, 128'({ch_map_wdata, col_map_wdata}), 128'd0);
    check({tag, "_glyphdata"}, ch_t_wdata, 128'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, c0, k0, g0;
  logic        seen_rdy;

  initial begin
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    apb.paddr_i = 16'd0; apb.pwdata_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    arstn = 1'b1;
    idle(2);

    // Char map write then read of entry 1.
    c0 = ch_cnt; k0 = col_cnt; g0 = gl_cnt;
    apb_xfer("chw", 1'b1, 16'h0004, 32'h0000_0041, 1'b0, rd, er, lat);
    check("chw_lat", 128'(lat), 128'd2);
    check("chw_err", 128'(er), 128'd0);
    check("chw_prdata", 128'(rd), 128'd0);
    idle(1);
    @(negedge clk);
    check("chw_pready_one_cycle", 128'(apb.pready_o), 128'd0);
    check("chw_pulses", 128'(ch_cnt - c0), 128'd1);
    check("chw_addr", 128'(ch_last_addr), 128'd1);
    check("chw_data", 128'(ch_last_data), 128'h41);
    check("chw_other_wen", 128'((col_cnt - k0) + (gl_cnt - g0)), 128'd0);
    apb_xfer("chr", 1'b0, 16'h0004, 32'd0, 1'b0, rd, er, lat);
    check("chr_lat", 128'(lat), 128'd3);
    check("chr_data", 128'(rd), 128'h41);
    idle(1);

    // Colour map last entry and first out-of-range entry.
    k0 = col_cnt;
    apb_xfer("colw", 1'b1, 16'h657C, 32'hFFFF_FFF0, 1'b0, rd, er, lat);
    check("colw_lat", 128'(lat), 128'd2);
    idle(1);
    check("colw_addr", 128'(col_last_addr), 128'd2399);
    check("colw_data", 128'(col_last_data), 128'hF0);
    apb_xfer("colr", 1'b0, 16'h657C, 32'd0, 1'b0, rd, er, lat);
    check("colr_data", 128'(rd), 128'hF0);
    check("colr_lat", 128'(lat), 128'd3);
    idle(1);
    c0 = ch_cnt; k0 = col_cnt; g0 = gl_cnt;
    apb_xfer("colbad_w", 1'b1, 16'h6580, 32'h55, 1'b0, rd, er, lat);
    check("colbad_w_err", 128'(er), 128'd1);
    check("colbad_w_lat", 128'(lat), 128'd2);
    apb_xfer("colbad_r", 1'b0, 16'h6580, 32'd0, 1'b0, rd, er, lat);
    check("colbad_r_err", 128'(er), 128'd1);
    check("colbad_r_data", 128'(rd), 128'd0);
    idle(1);
    check("colbad_no_wen", 128'((ch_cnt - c0) + (col_cnt - k0) + (gl_cnt - g0)), 128'd0);

    // Preload glyph 5 with ones through the bus, then patch word 2.
    for (int w = 0; w < 4; w++) begin
      apb_xfer("gpre", 1'b1, 16'h8050 + 16'(4 * w), 32'hFFFF_FFFF, 1'b0, rd, er, lat);
      idle(1);
    end
    check("glyph5_preload", gl_mem[5], {128{1'b1}});
    g0 = gl_cnt;
    apb_xfer("glw", 1'b1, 16'h8058, 32'h1234_5678, 1'b0, rd, er, lat);
    check("glw_lat", 128'(lat), 128'd4);
    check("glw_err", 128'(er), 128'd0);
    idle(1);
    check("glw_pulses", 128'(gl_cnt - g0), 128'd1);
    check("glw_addr", 128'(gl_last_addr), 128'd5);
    check("glw_data", gl_last_data, 128'hFFFFFFFF_12345678_FFFFFFFF_FFFFFFFF);
    apb_xfer("glr2", 1'b0, 16'h8058, 32'd0, 1'b0, rd, er, lat);
    check("glr2_lat", 128'(lat), 128'd3);
    check("glr2_data", 128'(rd), 128'h1234_5678);
    apb_xfer("glr1", 1'b0, 16'h8054, 32'd0, 1'b0, rd, er, lat);
    check("glr1_data", 128'(rd), 128'hFFFF_FFFF);
    idle(1);

    // Reserved region and out-of-range glyph index.
    c0 = ch_cnt; k0 = col_cnt; g0 = gl_cnt;
    apb_xfer("r11_r", 1'b0, 16'hC000, 32'd0, 1'b0, rd, er, lat);
    check("r11_r_err", 128'(er), 128'd1);
    check("r11_r_data", 128'(rd), 128'd0);
    check("r11_r_lat", 128'(lat), 128'd2);
    apb_xfer("r11_w", 1'b1, 16'hC000, 32'hDEAD_BEEF, 1'b0, rd, er, lat);
    check("r11_w_err", 128'(er), 128'd1);
    check("r11_w_lat", 128'(lat), 128'd2);
    apb_xfer("glbad", 1'b1, 16'h8800, 32'h1, 1'b0, rd, er, lat);
    check("glbad_err", 128'(er), 128'd1);
    idle(1);
    check("bad_no_wen", 128'((ch_cnt - c0) + (col_cnt - k0) + (gl_cnt - g0)), 128'd0);

    // PSEL dropped during DECODE of a glyph write: no pulse, no response.
    g0 = gl_cnt; seen_rdy = 1'b0;
    @(posedge clk); #1;
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b1;
    apb.paddr_i = 16'h8050; apb.pwdata_i = 32'd0;
    @(posedge clk); #1;
    apb.psel_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (apb.pready_o) seen_rdy = 1'b1;
    end
    check("abort_no_pready", 128'(seen_rdy), 128'd0);
    check("abort_no_wen", 128'(gl_cnt - g0), 128'd0);
    apb_xfer("abort_after", 1'b0, 16'h8050, 32'd0, 1'b0, rd, er, lat);
    check("abort_after_data", 128'(rd), 128'hFFFF_FFFF);
    idle(1);

    // Reset in RD_WAIT of a glyph write: the merge write never happens.
    g0 = gl_cnt;
    @(posedge clk); #1;
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b1;
    apb.paddr_i = 16'h805C; apb.pwdata_i = 32'd0;
    @(posedge clk); #1;
    apb.penable_i = 1'b1;
    @(posedge clk); #1;
    arstn = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    apb.psel_i = 1'b0; apb.penable_i = 1'b0;
    arstn = 1'b1;
    check("midrst_no_wen", 128'(gl_cnt - g0), 128'd0);
    check("midrst_glyph_kept", gl_mem[5], 128'hFFFFFFFF_12345678_FFFFFFFF_FFFFFFFF);
    c0 = ch_cnt;
    apb_xfer("postrst", 1'b1, 16'h000C, 32'h77, 1'b0, rd, er, lat);
    check("postrst_lat", 128'(lat), 128'd2);
    idle(1);
    check("postrst_wen", 128'(ch_cnt - c0), 128'd1);
    check("postrst_addr", 128'(ch_last_addr), 128'd3);

    // Back-to-back map write (bus changes in ACCESS) then glyph read.
    c0 = ch_cnt;
    apb_xfer("b2b_w", 1'b1, 16'h0008, 32'h0000_005A, 1'b1, rd, er, lat);
    check("b2b_w_lat", 128'(lat), 128'd2);
    apb_xfer("b2b_r", 1'b0, 16'h8058, 32'd0, 1'b0, rd, er, lat);
    check("b2b_r_lat", 128'(lat), 128'd3);
    check("b2b_r_data", 128'(rd), 128'h1234_5678);
    idle(1);
    check("b2b_w_pulses", 128'(ch_cnt - c0), 128'd1);
    check("b2b_w_addr", 128'(ch_last_addr), 128'd2);
    check("b2b_w_data", 128'(ch_last_data), 128'h5A);

    idle(2);
    check("single_wen", 128'(multi_wen), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
